// File: rtl/iterative_divider32_if.sv
// rtl/iterative_divider32_if.sv - start_div/div_ready handshake between control unit and divider
//
// Signals:
//   start_div  request pulse from the control unit
//   div_op     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend   operand A
//   divisor    operand B
//   div_busy   divider is iterating
//   div_ready  one-cycle result-valid pulse
//   result     quotient or remainder, held until the next accepted start
// Modports: master = control unit, slave = divider.
interface iterative_divider32_if #(
    parameter int WIDTH = 32
);
    logic             start_div;
    logic [1:0]       div_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             div_busy;
    logic             div_ready;
    logic [WIDTH-1:0] result;

    modport master (
        output start_div, div_op, dividend, divisor,
        input  div_busy, div_ready, result
    );

    modport slave (
        input  start_div, div_op, dividend, divisor,
        output div_busy, div_ready, result
    );
endinterface

// File: rtl/iterative_divider32.sv
// rtl/iterative_divider32.sv - multi-cycle restoring divider for RISC-V DIV/DIVU/REM/REMU
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-high reset
//   bus    slave side of iterative_divider32_if (start_div, div_op, dividend,
//          divisor in; div_busy, div_ready, result out)
// Divide-by-zero and signed overflow finish at the accept edge. Otherwise the
// accept edge performs the first of 32 quotient-bit iterations, so the result
// is written on the 32nd edge counting the accept edge.
module iterative_divider32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    iterative_divider32_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state;
    state_t             state_nxt;

    logic [1:0]         op_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   dvs_r;
    logic [CNT_W-1:0]   cnt;
    logic               neg_q_r;
    logic               neg_r_r;
    logic [WIDTH-1:0]   result_r;

    // Operand decode at the accept edge
    logic               accept;
    logic               op_signed;
    logic               op_rem;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               div_zero;
    logic               sovf;
    logic               fast;
    logic [WIDTH-1:0]   fast_res;

    assign accept    = bus.start_div && (state != S_RUN);
    assign op_signed = ~bus.div_op[0];
    assign op_rem    = bus.div_op[1];
    assign a_neg     = op_signed & bus.dividend[WIDTH-1];
    assign b_neg     = op_signed & bus.divisor[WIDTH-1];
    // Negating the most negative value yields itself, which is the correct
    // magnitude once read as unsigned.
    assign abs_a     = a_neg ? -bus.dividend : bus.dividend;
    assign abs_b     = b_neg ? -bus.divisor  : bus.divisor;
    assign div_zero  = (bus.divisor == '0);
    assign sovf      = op_signed && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                       && (bus.divisor == '1);
    assign fast      = div_zero | sovf;
    // Overflow: quotient equals the dividend (most negative value), remainder 0.
    assign fast_res  = div_zero ? (op_rem ? bus.dividend : '1)
                                : (op_rem ? '0 : bus.dividend);

    // One restoring step; fed from fresh operands on the accept edge and from
    // the working registers while running.
    logic [WIDTH-1:0]   it_rem;
    logic [WIDTH-1:0]   it_quo;
    logic [WIDTH-1:0]   it_dvs;
    logic [WIDTH:0]     shifted;
    logic               take;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic               last;
    logic [WIDTH-1:0]   final_res;

    assign it_rem  = accept ? '0    : rem_r;
    assign it_quo  = accept ? abs_a : quo_r;
    assign it_dvs  = accept ? abs_b : dvs_r;
    assign shifted = {it_rem, it_quo[WIDTH-1]};
    assign take    = (shifted >= {1'b0, it_dvs});
    // The remainder is always below the divisor, so WIDTH bits hold it and the
    // subtraction may be taken modulo 2^WIDTH.
    assign rem_nxt = take ? (shifted[WIDTH-1:0] - it_dvs) : shifted[WIDTH-1:0];
    assign quo_nxt = {it_quo[WIDTH-2:0], take};
    assign last    = (state == S_RUN) && (cnt == '1);
    assign final_res = op_r[1] ? (neg_r_r ? -rem_nxt : rem_nxt)
                               : (neg_q_r ? -quo_nxt : quo_nxt);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start_div) begin
                    state_nxt = fast ? S_DONE : S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.div_busy  = (state == S_RUN);
        bus.div_ready = (state == S_DONE);
        bus.result    = result_r;
    end

    // Datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r     <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
            dvs_r    <= '0;
            cnt      <= '0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            result_r <= '0;
        end else if (accept) begin
            op_r <= bus.div_op;
            if (fast) begin
                result_r <= fast_res;
            end else begin
                rem_r   <= rem_nxt;
                quo_r   <= quo_nxt;
                dvs_r   <= abs_b;
                cnt     <= CNT_W'(1);
                neg_q_r <= a_neg ^ b_neg;
                neg_r_r <= a_neg;
            end
        end else if (state == S_RUN) begin
            rem_r <= rem_nxt;
            quo_r <= quo_nxt;
            cnt   <= cnt + 1'b1;
            if (last) begin
                result_r <= final_res;
            end
        end
    end
endmodule

// File: tb/tb_iterative_divider32.sv
// tb/tb_iterative_divider32.sv - directed self-checking bench for iterative_divider32
module tb_iterative_divider32;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    iterative_divider32_if dif ();

    iterative_divider32 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation and watch it to completion. lat counts sampled
    // cycles after the accept edge up to and including the div_ready cycle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_cnt,
                         output logic ready_after, output logic held);
        logic [31:0] prev;
        logic        seen;
        @(negedge clk);
        prev          = dif.result;
        dif.div_op    = op;
        dif.dividend  = a;
        dif.divisor   = b;
        dif.start_div = 1'b1;
        @(posedge clk);
        #1;
        dif.start_div = 1'b0;
        dif.dividend  = 32'hDEAD_BEEF;
        dif.divisor   = 32'h0000_0003;
        lat      = 0;
        busy_cnt = 0;
        res      = 32'hx;
        held     = 1'b1;
        seen     = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (dif.div_ready) begin
                res  = dif.result;
                seen = 1'b1;
            end else begin
                if (dif.div_busy) busy_cnt++;
                if (dif.result !== prev) held = 1'b0;
            end
        end
        @(negedge clk);
        ready_after = dif.div_ready;
    endtask

    task automatic test_reset();
        checks++;
        if (dif.div_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", dif.div_busy);
        end
        checks++;
        if (dif.div_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b want 0", dif.div_ready);
        end
        checks++;
        if (dif.result !== 32'h0) begin
            errors++; $display("FAIL reset_result: got %h want 0", dif.result);
        end
    endtask

    task automatic test_unsigned();
        logic [31:0] res;
        int lat, bc;
        logic ra, held;
        do_op(OP_DIVU, 32'd100, 32'd7, res, lat, bc, ra, held);
        checks++;
        if (res !== 32'd14) begin errors++; $display("FAIL divu_100_7: got %h want %h", res, 32'd14); end
        checks++;
        if (lat != 32) begin errors++; $display("FAIL divu_latency: got %0d want 32", lat); end
        checks++;
        if (bc != 31) begin errors++; $display("FAIL divu_busy_cycles: got %0d want 31", bc); end
        checks++;
        if (ra !== 1'b0) begin errors++; $display("FAIL divu_ready_one_cycle: got %b want 0", ra); end
        checks++;
        if (held !== 1'b1) begin errors++; $display("FAIL divu_result_held: got %b want 1", held); end
        do_op(OP_REMU, 32'd100, 32'd7, res, lat, bc, ra, held);
        checks++;
        if (res !== 32'd2) begin errors++; $display("FAIL remu_100_7: got %h want %h", res, 32'd2); end
    endtask

    task automatic test_signed();
        logic [1:0]  ops  [4] = '{OP_DIV, OP_REM, OP_REM, OP_DIV};
        logic [31:0] as   [4] = '{32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd100, 32'h8000_0000};
        logic [31:0] bs   [4] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'd2};
        logic [31:0] exps [4] = '{32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'd2, 32'hC000_0000};
        logic [31:0] res;
        int lat, bc;
        logic ra, held;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], res, lat, bc, ra, held);
            checks++;
            if (res !== exps[i]) begin
                errors++; $display("FAIL signed_%0d: got %h want %h", i, res, exps[i]);
            end
            checks++;
            if (lat != 32) begin
                errors++; $display("FAIL signed_latency_%0d: got %0d want 32", i, lat);
            end
        end
    endtask

    task automatic test_fast_path();
        logic [1:0]  ops  [4] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] as   [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exps [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] res;
        int lat, bc;
        logic ra, held;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], res, lat, bc, ra, held);
            checks++;
            if (res !== exps[i]) begin
                errors++; $display("FAIL fast_%0d: got %h want %h", i, res, exps[i]);
            end
            checks++;
            if (lat != 1) begin
                errors++; $display("FAIL fast_latency_%0d: got %0d want 1", i, lat);
            end
            checks++;
            if (bc != 0) begin
                errors++; $display("FAIL fast_busy_%0d: got %0d want 0", i, bc);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic seen;
        @(negedge clk);
        dif.div_op    = OP_DIVU;
        dif.dividend  = 32'd100;
        dif.divisor   = 32'd7;
        dif.start_div = 1'b1;
        @(posedge clk);
        #1;
        dif.start_div = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 5) begin
                dif.dividend  = 32'd9;
                dif.divisor   = 32'd2;
                dif.start_div = 1'b1;
            end else begin
                dif.start_div = 1'b0;
            end
            if (dif.div_ready) seen = 1'b1;
        end
        checks++;
        if (lat != 32) begin errors++; $display("FAIL ignore_latency: got %0d want 32", lat); end
        checks++;
        if (dif.result !== 32'd14) begin
            errors++; $display("FAIL ignore_result: got %h want %h", dif.result, 32'd14);
        end
        // Still in the DONE cycle: request the next operation here.
        dif.div_op    = OP_DIVU;
        dif.dividend  = 32'd9;
        dif.divisor   = 32'd2;
        dif.start_div = 1'b1;
        @(posedge clk);
        #1;
        dif.start_div = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (dif.div_ready) seen = 1'b1;
        end
        checks++;
        if (lat != 32) begin errors++; $display("FAIL b2b_latency: got %0d want 32", lat); end
        checks++;
        if (dif.result !== 32'd4) begin
            errors++; $display("FAIL b2b_result: got %h want %h", dif.result, 32'd4);
        end
    endtask

    task automatic test_abort();
        int readies;
        logic [31:0] res;
        int lat, bc;
        logic ra, held;
        @(negedge clk);
        dif.div_op    = OP_DIVU;
        dif.dividend  = 32'd100;
        dif.divisor   = 32'd7;
        dif.start_div = 1'b1;
        @(posedge clk);
        #1;
        dif.start_div = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (dif.div_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", dif.div_busy); end
        checks++;
        if (dif.div_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", dif.div_ready); end
        checks++;
        if (dif.result !== 32'h0) begin errors++; $display("FAIL abort_result: got %h want 0", dif.result); end
        @(negedge clk);
        reset   = 1'b0;
        readies = 0;
        repeat (40) begin
            @(negedge clk);
            if (dif.div_ready) readies++;
        end
        checks++;
        if (readies != 0) begin errors++; $display("FAIL abort_no_ready: got %0d want 0", readies); end
        do_op(OP_DIVU, 32'd8, 32'd3, res, lat, bc, ra, held);
        checks++;
        if (res !== 32'd2) begin errors++; $display("FAIL after_abort_result: got %h want %h", res, 32'd2); end
        checks++;
        if (lat != 32) begin errors++; $display("FAIL after_abort_latency: got %0d want 32", lat); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        dif.start_div = 1'b0;
        dif.div_op    = 2'b00;
        dif.dividend  = 32'h0;
        dif.divisor   = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_unsigned();
        test_signed();
        test_fast_path();
        test_back_to_back();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
